ps2_frame_decoder: RTL and testbench
====================================

Name: ps2_frame_decoder

Overview:
- Serial-frame consumer that sits directly downstream of the keyboard line sampler.
- Takes the same sampled data bit and bit-enable strobe the start detector uses, and frames an 11-bit PS/2-style packet: start=0, 8 data bits LSB-first, odd parity, stop=1.
- Checks parity and stop, tracks the 0xF0 break prefix, and delivers one scan code per keystroke event to the calculator key-decode logic.
- Includes an inter-bit watchdog so a truncated frame cannot wedge the receiver.

Parameters:
- TIMEOUT_CYCLES, 4096, clk cycles allowed between consecutive en strobes inside a frame before abort.
- BREAK_CODE, 8'hF0, prefix byte marking a key release.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a clk edge resets the block.
- data  input  1  sampled serial line bit, valid when en==1.
- en  input  1  one-cycle bit strobe; exactly one serial bit is consumed per en cycle.
- code  output  8  last accepted scan code; held until the next accepted frame.
- code_valid  output  1  one-cycle pulse when code updates.
- release  output  1  qualifies code_valid; 1 means the code was preceded by BREAK_CODE.
- frame_err  output  1  one-cycle pulse on parity error, stop error or timeout.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; code=8'h00; code_valid=0; release=0; frame_err=0; busy=0.
  - Shift register, bit counter, watchdog and break flag all cleared.
  - Reset has priority over every other event, including mid-frame and on an en cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only on cycles where en==1, except the timeout.
- IDLE:
  - en&&data==0 -> DATA; bit count=0; parity accumulator=0.
  - en&&data==1 is ignored (idle line).
- DATA:
  - Each en shifts data into bit[count] (LSB first) and XORs it into the accumulator.
  - After the 8th bit (count==7 on en) -> PARITY.
- PARITY:
  - On en, latch the bit.
  - Parity is good iff XOR(data[7:0], parity bit)==1 (odd parity).
  - -> STOP.
- STOP, on en:
  - data==1 and parity good: frame accepted.
  - Otherwise: frame_err pulses the next cycle, and the break flag is left unchanged.
  - Either way -> IDLE.
- Accepted frame:
  - byte==BREAK_CODE: set the break flag; no code_valid.
  - Any other byte: code<=byte; release<=break flag; code_valid pulses 1 cycle; break flag cleared.
  - Outputs register one cycle after the stop-bit en.
  - Two consecutive BREAK_CODE frames: the flag stays set; the next non-F0 byte is reported once as a release.
- Watchdog:
  - Counts clk cycles since the last en while busy, and clears on every en.
  - On reaching TIMEOUT_CYCLES-1 without en: -> IDLE, frame_err pulses, partial byte is discarded, break flag is preserved.
  - If en arrives on the same cycle the count reaches the limit, en wins and no timeout occurs.
- code_valid and frame_err are never high in the same cycle.
- A start bit can be accepted on the en immediately following the stop-bit en; no dead cycle is required.
- busy=1 from the cycle after the start-bit en through the cycle the FSM returns to IDLE.
- Watchdog width is clog2(TIMEOUT_CYCLES). Counter wrap is impossible because the timeout forces IDLE.

Decomposition:
- Shared keyboard package:
  - State enum: IDLE/DATA/PARITY/STOP, 2-bit encoding.
  - Constants FRAME_BITS=11 and BREAK_CODE default.
- One natural sub-module: ps2_bit_watchdog (counter, clear on en, enable on busy, timeout pulse out). Everything else stays in the top FSM.

Test Plan:
- Valid make code 0x1C (bits 0,0,0,1,1,1,0,0,0 LSB-first, parity 0, stop 1), en every 4 cycles -> code=8'h1C, release=0, code_valid pulses once, frame_err stays 0.
- Frames F0 then 0x1C back-to-back -> a single code_valid with code=8'h1C, release=1; no pulse for F0.
- Frame 0x45 with the parity bit inverted -> frame_err one pulse; code keeps its previous value; next good frame 0x16 is decoded correctly.
- Start plus 3 data bits then no en for TIMEOUT_CYCLES -> frame_err pulse; busy falls; subsequent frame 0x29 is decoded.
- reset driven to 0 for one cycle after 5 data bits of a frame -> all outputs 0 and state IDLE; the next full frame 0x5A is decoded normally.
- Stop bit sampled as 0 on frame 0x32 -> frame_err pulse; no code_valid.

Source files
------------

// File: rtl/ps2_frame_decoder_pkg.sv
// Shared keyboard-path definitions: frame FSM state encoding and PS/2 framing constants.
package ps2_frame_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int          FRAME_BITS     = 11;
    localparam int          DATA_BITS      = 8;
    localparam logic [7:0]  BREAK_CODE_DEF = 8'hF0;

endpackage

// File: rtl/ps2_bit_watchdog.sv
// Inter-bit watchdog: counts clk cycles between bit strobes while a frame is in progress.
module ps2_bit_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_i,
    input  logic en_i,
    input  logic busy_i,
    output logic timeout_o
);

    localparam int             CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A strobe arriving on the limit cycle wins over the timeout.
    assign timeout_o = busy_i && !en_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (en_i || !busy_i || timeout_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_frame_decoder.sv
// Frames 11-bit PS/2 packets from the sampled line, checks parity/stop, and reports
// make/break scan codes to the key-decode logic.
module ps2_frame_decoder
    import ps2_frame_decoder_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] BREAK_CODE     = BREAK_CODE_DEF
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       data_i,
    input  logic       en_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    output logic       release_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    ps2_state_e state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       par_q;
    logic       break_q;
    logic [7:0] code_q;
    logic       code_valid_q;
    logic       release_q;
    logic       frame_err_q;
    logic       timeout;

    ps2_bit_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_i  (reset_i),
        .en_i     (en_i),
        .busy_i   (busy_o),
        .timeout_o(timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            break_q      <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            release_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (timeout) begin
                // Abandon the partial byte; a pending break prefix survives.
                state_q     <= ST_IDLE;
                shift_q     <= '0;
                bit_cnt_q   <= '0;
                frame_err_q <= 1'b1;
            end else if (en_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_i) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                            par_q     <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shift_q[bit_cnt_q] <= data_i;
                        par_q              <= par_q ^ data_i;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        // After this XOR, par_q==1 means odd parity held.
                        par_q   <= par_q ^ data_i;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (data_i && par_q) begin
                            if (shift_q == BREAK_CODE) begin
                                break_q <= 1'b1;
                            end else begin
                                code_q       <= shift_q;
                                release_q    <= break_q;
                                code_valid_q <= 1'b1;
                                break_q      <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = code_valid_q;
    assign release_o    = release_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Scoreboard bench: stimulus pushes expected code/error events, a negedge monitor pops them.
module tb_ps2_frame_decoder;
    import ps2_frame_decoder_pkg::*;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       data_i;
    logic       en_i;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       release_o;
    logic       frame_err_o;
    logic       busy_o;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         rel;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ps2_frame_decoder #(
        .TIMEOUT_CYCLES(T),
        .BREAK_CODE    (8'hF0)
    ) dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .data_i      (data_i),
        .en_i        (en_i),
        .code_o      (code_o),
        .code_valid_o(code_valid_o),
        .release_o   (release_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every code_valid or frame_err pulse consumes one expected event.
    always @(negedge clk) begin
        if (reset_i === 1'b1 && (code_valid_o === 1'b1 || frame_err_o === 1'b1)) begin
            check("pulse_exclusive", {31'd0, code_valid_o & frame_err_o}, 32'd0);
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, code_valid_o, frame_err_o}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("kind_is_err", {31'd0, frame_err_o}, {31'd0, e.is_err});
                check("code", {24'd0, code_o}, {24'd0, e.code});
                if (!e.is_err) begin
                    check("release", {31'd0, release_o}, {31'd0, e.rel});
                end
                $display("txn err=%0b code=0x%02h rel=%0b (expected err=%0b code=0x%02h rel=%0b)",
                         frame_err_o, code_o, release_o, e.is_err, e.code, e.rel);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        data_i = b;
        en_i   = 1'b1;
        tick();
        en_i   = 1'b0;
        data_i = 1'b1;
        repeat (gap - 1) tick();
    endtask

    // Full frame; flip_par inverts the parity bit, stop sets the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop, input int gap);
        logic par;
        par = ~(^b) ^ flip_par;
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(b[i], gap);
        send_bit(par, gap);
        send_bit(stop, gap);
    endtask

    task automatic push(input bit is_err, input logic [7:0] c, input bit rel);
        exp_t e;
        e.is_err = is_err;
        e.code   = c;
        e.rel    = rel;
        q.push_back(e);
    endtask

    initial begin
        int n;
        reset_i = 1'b0;
        data_i  = 1'b1;
        en_i    = 1'b0;
        repeat (3) tick();
        check("rst_code", {24'd0, code_o}, 32'd0);
        check("rst_outs", {28'd0, code_valid_o, release_o, frame_err_o, busy_o}, 32'd0);
        reset_i = 1'b1;
        repeat (2) tick();

        // Idle-line strobes must not start a frame.
        send_bit(1'b1, 2);
        check("idle_ignored_busy", {31'd0, busy_o}, 32'd0);

        // Plain make code; busy asserted right after the start bit.
        push(1'b0, 8'h1C, 1'b0);
        send_bit(1'b0, 1);
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0, 4);
        send_bit(1'b0, 4);
        send_bit(1'b1, 4);
        check("busy_after_stop", {31'd0, busy_o}, 32'd0);

        // Break prefix then make, back-to-back with en every cycle.
        push(1'b0, 8'h1C, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1, 1);
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        repeat (3) tick();

        // Bad parity, then recovery.
        push(1'b1, 8'h1C, 1'b0);
        send_frame(8'h45, 1'b1, 1'b1, 2);
        push(1'b0, 8'h16, 1'b0);
        send_frame(8'h16, 1'b0, 1'b1, 2);

        // Two break prefixes and an error frame keep the flag; it clears after one report.
        push(1'b1, 8'h16, 1'b0);
        push(1'b0, 8'h1C, 1'b1);
        push(1'b0, 8'h16, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1);
        send_frame(8'hF0, 1'b0, 1'b1, 1);
        send_frame(8'h45, 1'b1, 1'b1, 1);
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        send_frame(8'h16, 1'b0, 1'b1, 1);
        repeat (3) tick();

        // Truncated frame: watchdog fires T cycles after the last strobe.
        push(1'b1, 8'h16, 1'b0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        n = 0;
        while (busy_o === 1'b1 && n < 3 * T) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, T);
        check("busy_after_timeout", {31'd0, busy_o}, 32'd0);

        // Strobes exactly at the watchdog limit must not time out.
        push(1'b0, 8'h29, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1, T);
        repeat (3) tick();

        // Reset mid-frame clears outputs and the pending break flag.
        send_frame(8'hF0, 1'b0, 1'b1, 2);
        send_bit(1'b0, 1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        check("midrst_code", {24'd0, code_o}, 32'd0);
        check("midrst_outs", {28'd0, code_valid_o, release_o, frame_err_o, busy_o}, 32'd0);
        push(1'b0, 8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 3);

        // Stop bit low.
        push(1'b1, 8'h5A, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0, 3);
        repeat (5) tick();

        check("scoreboard_drained", q.size(), 0);
        check("frame_bits_const", FRAME_BITS, 11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
